// File: rtl/vga_pixel_pipeline.sv
// Pixel pipeline between the VGA controller and the DAC: coordinate -> vram address,
// palette lookup of the returned index, and sync/blank delayed to stay aligned with colour.
module vga_pixel_pipeline #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int VRAM_A_WIDTH  = 19,
  parameter int VRAM_D_WIDTH  = 6,
  parameter int VRAM_LATENCY  = 1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [9:0]              draw_x,
  input  logic [9:0]              draw_y,
  input  logic                    active,
  input  logic                    hs_in,
  input  logic                    vs_in,
  output logic [VRAM_A_WIDTH-1:0] vram_addr,
  input  logic [VRAM_D_WIDTH-1:0] vram_data,
  input  logic                    pal_valid,
  output logic                    pal_ready,
  input  logic [VRAM_D_WIDTH-1:0] pal_addr,
  input  logic [11:0]             pal_data,
  output logic [7:0]              vga_r,
  output logic [7:0]              vga_g,
  output logic [7:0]              vga_b,
  output logic                    vga_hs,
  output logic                    vga_vs,
  output logic                    vga_blank_n,
  output logic [15:0]             frame_cnt
);
  localparam int         DLY       = VRAM_LATENCY + 2;
  localparam int         PAL_DEPTH = 2 ** VRAM_D_WIDTH;
  localparam logic [9:0] X_LIM     = 10'(SCREEN_WIDTH);
  localparam logic [9:0] Y_LIM     = 10'(SCREEN_HEIGHT);

  typedef enum logic {PAL_IDLE = 1'b0, PAL_PENDING = 1'b1} pal_state_e;

  logic [VRAM_A_WIDTH-1:0] x_ext_s, y_ext_s, vram_addr_d, vram_addr_q;
  logic [2:0]              sync_q [DLY];
  logic [2:0]              sync_out_s;
  logic [11:0]             pal_ram_q [PAL_DEPTH];
  logic [11:0]             pal_rd_q;
  logic [7:0]              r_q, g_q, b_q;
  logic                    hs_q, vs_q, blank_n_q;
  logic [15:0]             frame_cnt_q;
  pal_state_e              pal_state_q;
  logic                    pal_ready_q;
  logic [VRAM_D_WIDTH-1:0] pend_addr_q;
  logic [11:0]             pend_data_q;
  logic                    pal_we_s;
  logic [VRAM_D_WIDTH-1:0] pal_wa_s;
  logic [11:0]             pal_wd_s;

  assign x_ext_s    = VRAM_A_WIDTH'(draw_x);
  assign y_ext_s    = VRAM_A_WIDTH'(draw_y);
  assign sync_out_s = sync_q[DLY-1];

  // Stage A address: off-screen coordinates fold to address 0.
  always_comb begin
    vram_addr_d = '0;
    if (draw_x >= X_LIM || draw_y >= Y_LIM) begin
      vram_addr_d = '0;
    end else if (SCREEN_WIDTH == 640) begin
      vram_addr_d = (y_ext_s << 9) + (y_ext_s << 7) + x_ext_s;
    end else begin
      vram_addr_d = y_ext_s * VRAM_A_WIDTH'(SCREEN_WIDTH) + x_ext_s;
    end
  end

  // Address register, {active,hs,vs} delay line and registered palette read.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vram_addr_q <= '0;
      pal_rd_q    <= 12'h000;
      for (int i = 0; i < DLY; i++) sync_q[i] <= 3'b011;
    end else begin
      vram_addr_q <= vram_addr_d;
      pal_rd_q    <= pal_ram_q[vram_data];
      sync_q[0]   <= {active, hs_in, vs_in};
      for (int i = 1; i < DLY; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Output register; frame count follows the falling edge of the delayed vsync.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_q         <= 8'h00;
      g_q         <= 8'h00;
      b_q         <= 8'h00;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      blank_n_q   <= 1'b0;
      frame_cnt_q <= 16'h0000;
    end else begin
      if (sync_out_s[2]) begin
        r_q <= {pal_rd_q[11:8], pal_rd_q[11:8]};
        g_q <= {pal_rd_q[7:4],  pal_rd_q[7:4]};
        b_q <= {pal_rd_q[3:0],  pal_rd_q[3:0]};
      end else begin
        r_q <= 8'h00;
        g_q <= 8'h00;
        b_q <= 8'h00;
      end
      hs_q      <= sync_out_s[1];
      vs_q      <= sync_out_s[0];
      blank_n_q <= sync_out_s[2];
      if (vs_q && !sync_out_s[0]) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  // Write decode: blanking-time accepts go straight in, deferred ones wait for blanking.
  always_comb begin
    pal_we_s = 1'b0;
    pal_wa_s = pal_addr;
    pal_wd_s = pal_data;
    case (pal_state_q)
      PAL_IDLE: begin
        if (pal_valid && pal_ready_q && !active) pal_we_s = 1'b1;
        else                                     pal_we_s = 1'b0;
      end
      PAL_PENDING: begin
        pal_wa_s = pend_addr_q;
        pal_wd_s = pend_data_q;
        if (!active) pal_we_s = 1'b1;
        else         pal_we_s = 1'b0;
      end
      default: pal_we_s = 1'b0;
    endcase
  end

  // Palette write FSM with registered ready.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pal_state_q <= PAL_IDLE;
      pal_ready_q <= 1'b1;
      pend_addr_q <= '0;
      pend_data_q <= 12'h000;
    end else begin
      case (pal_state_q)
        PAL_IDLE: begin
          if (pal_valid && pal_ready_q && active) begin
            pend_addr_q <= pal_addr;
            pend_data_q <= pal_data;
            pal_state_q <= PAL_PENDING;
            pal_ready_q <= 1'b0;
          end
        end
        PAL_PENDING: begin
          if (!active) begin
            pal_state_q <= PAL_IDLE;
            pal_ready_q <= 1'b1;
          end
        end
        default: begin
          pal_state_q <= PAL_IDLE;
          pal_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Palette storage keeps its contents across reset.
  always_ff @(posedge Clk) begin
    if (pal_we_s) pal_ram_q[pal_wa_s] <= pal_wd_s;
  end

  assign vram_addr   = vram_addr_q;
  assign pal_ready   = pal_ready_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign frame_cnt   = frame_cnt_q;
endmodule
